// File: rtl/btn_conditioner.sv
// btn_conditioner: per-channel push-button conditioning.
//   Each channel runs a two-flop synchronizer and a saturating debounce
//   counter, and produces one-cycle press/release strobes.
//   Optional auto-repeat: define BTN_AUTOREPEAT_EN to add a per-channel
//   IDLE / HELD_DELAY / HELD_REPEAT machine that re-fires btn_pulse while held.
// Ports:
//   clk         - rising-edge clock
//   reset       - synchronous, active-high reset
//   btn_raw     - asynchronous, bouncing button inputs (bit i = channel i)
//   btn_level   - debounced level, 1 = pressed
//   btn_pulse   - one-cycle strobe per accepted press (plus repeats if enabled)
//   btn_release - one-cycle strobe per accepted release
module btn_conditioner #(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_release
);

  // Zero-length debounce or repeat intervals have no meaning.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("btn_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [N_BTN-1:0] rise_c;
  logic [N_BTN-1:0] fall_c;

  // Two-flop synchronizer for the asynchronous button inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    logic [DB_W-1:0] db_cnt;
    logic            toggle_c;

    // Accept the new level on the cycle the mismatch count reaches DEBOUNCE_CYCLES.
    assign toggle_c  = (sync2[i] != btn_level[i]) && (db_cnt == DB_LAST);
    assign rise_c[i] = toggle_c && !btn_level[i];
    assign fall_c[i] = toggle_c &&  btn_level[i];

    // Debounce counter: counts mismatch cycles, clears on agreement or on acceptance.
    always_ff @(posedge clk) begin
      if (reset) begin
        db_cnt <= '0;
      end else if (sync2[i] == btn_level[i]) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt <= '0;
      end else if (db_cnt != '1) begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end

    // Debounced level and release strobe.
    always_ff @(posedge clk) begin
      if (reset) begin
        btn_level[i]   <= 1'b0;
        btn_release[i] <= 1'b0;
      end else begin
        if (toggle_c) begin
          btn_level[i] <= ~btn_level[i];
        end
        btn_release[i] <= fall_c[i];
      end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RP_W   = $clog2(RP_MAX + 1);
    localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
      IDLE        = 2'd0,
      HELD_DELAY  = 2'd1,
      HELD_REPEAT = 2'd2
    } rep_state_t;

    rep_state_t      state;
    logic [RP_W-1:0] rp_cnt;

    // Auto-repeat machine; a falling level always wins so no repeat meets a release.
    always_ff @(posedge clk) begin
      if (reset) begin
        state        <= IDLE;
        rp_cnt       <= '0;
        btn_pulse[i] <= 1'b0;
      end else begin
        btn_pulse[i] <= rise_c[i];
        if (fall_c[i]) begin
          state  <= IDLE;
          rp_cnt <= '0;
        end else begin
          case (state)
            IDLE: begin
              rp_cnt <= '0;
              if (rise_c[i]) begin
                state <= HELD_DELAY;
              end
            end
            HELD_DELAY: begin
              if (rp_cnt == DELAY_LAST) begin
                btn_pulse[i] <= 1'b1;
                state        <= HELD_REPEAT;
                rp_cnt       <= '0;
              end else begin
                rp_cnt <= rp_cnt + RP_W'(1);
              end
            end
            HELD_REPEAT: begin
              if (rp_cnt == PERIOD_LAST) begin
                btn_pulse[i] <= 1'b1;
                rp_cnt       <= '0;
              end else begin
                rp_cnt <= rp_cnt + RP_W'(1);
              end
            end
            default: begin
              state  <= IDLE;
              rp_cnt <= '0;
            end
          endcase
        end
      end
    end
`else
    // Single press strobe only.
    always_ff @(posedge clk) begin
      if (reset) begin
        btn_pulse[i] <= 1'b0;
      end else begin
        btn_pulse[i] <= rise_c[i];
      end
    end
`endif
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Testbench for btn_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3. Table of per-edge vectors plus hand-written sequences
// for auto-repeat and reset during a held press.
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_pulse;
  logic [3:0] btn_release;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rst;
    logic [3:0] raw;
    logic [3:0] lvl;
    logic [3:0] pul;
    logic [3:0] rel;
  } vec_t;

  vec_t vecs[$];

  btn_conditioner #(
    .N_BTN(4),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic [3:0] raw, input logic [3:0] lvl,
                     input logic [3:0] pul, input logic [3:0] rel, input int n);
    vec_t v;
    v.rst = rst; v.raw = raw; v.lvl = lvl; v.pul = pul; v.rel = rel;
    repeat (n) vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  // Apply inputs, take one edge, then sample just after it.
  task automatic step(input string tag, input int idx, input logic rst, input logic [3:0] raw,
                      input logic [3:0] el, input logic [3:0] ep, input logic [3:0] er);
    reset   = rst;
    btn_raw = raw;
    @(posedge clk);
    #1;
    cmp({tag, ".level"},   idx, btn_level,   el);
    cmp({tag, ".pulse"},   idx, btn_pulse,   ep);
    cmp({tag, ".release"}, idx, btn_release, er);
  endtask

  initial begin
    bit ar;
    logic [3:0] el, ep, er, raw;
`ifdef BTN_AUTOREPEAT_EN
    ar = 1'b1;
`else
    ar = 1'b0;
`endif
    reset   = 1'b1;
    btn_raw = 4'b0000;

    // Reset held with no buttons
    add(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 10);
    // Channel 1 press: level and pulse after the 6th edge
    add(1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 5);
    add(1'b0, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 1);
    add(1'b0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1);
    // Channel 1 release, same latency
    add(1'b0, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 5);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 1);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
    // Channel 2 glitch of 3 cycles is rejected
    add(1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 3);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 6);
    // Channels 0 and 3 pressed together, then released together
    add(1'b0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 5);
    add(1'b0, 4'b1001, 4'b1001, 4'b1001, 4'b0000, 1);
    add(1'b0, 4'b1001, 4'b1001, 4'b0000, 4'b0000, 1);
    add(1'b0, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 5);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1001, 1);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2);
    // Reset mid-debounce aborts; full latency restarts after reset
    add(1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 3);
    add(1'b1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1);
    add(1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 5);
    add(1'b0, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 1);
    add(1'b0, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 5);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 1);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2);

    foreach (vecs[k]) begin
      step("vec", k, vecs[k].rst, vecs[k].raw, vecs[k].lvl, vecs[k].pul, vecs[k].rel);
    end

    // Channel 3 held: raw high before edges 1..19, low from edge 20.
    // Repeats at 16, 19, 22; the edge-25 slot coincides with release and must not fire.
    for (int e = 1; e <= 35; e++) begin
      raw = (e <= 19) ? 4'b1000 : 4'b0000;
      el  = (e >= 6 && e <= 24) ? 4'b1000 : 4'b0000;
      ep  = (e == 6 || (ar && (e == 16 || e == 19 || e == 22))) ? 4'b1000 : 4'b0000;
      er  = (e == 25) ? 4'b1000 : 4'b0000;
      step("repeat", e, 1'b0, raw, el, ep, er);
    end

    // Channel 1 held, reset pulsed at edge 8; press recurs at edge 14.
    for (int e = 1; e <= 24; e++) begin
      raw = (e <= 16) ? 4'b0010 : 4'b0000;
      el  = ((e >= 6 && e <= 7) || (e >= 14 && e <= 21)) ? 4'b0010 : 4'b0000;
      ep  = (e == 6 || e == 14) ? 4'b0010 : 4'b0000;
      er  = (e == 22) ? 4'b0010 : 4'b0000;
      step("rst_held", e, (e == 8), raw, el, ep, er);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
- REQ-001: Parameter N_BTN, default 4; number of independent button channels.
- REQ-002: Parameter DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz); consecutive stable cycles required to accept a level change; legal range is 1 or more.
- REQ-003: Parameter REPEAT_DELAY, default 50000000; cycles from the press pulse to the first auto-repeat pulse; legal range is 1 or more.
- REQ-004: Parameter REPEAT_PERIOD, default 10000000; cycles between successive auto-repeat pulses; legal range is 1 or more.
- REQ-005: Port clk, input, 1 bit; the single clock, rising-edge active.
- REQ-006: Port reset, input, 1 bit; reset is synchronous and active-high.
- REQ-007: Port btn_raw, input, N_BTN bits; asynchronous, bouncing push-button inputs; bit i belongs to channel i.
- REQ-008: Port btn_level, output, N_BTN bits; debounced button level, 1 = pressed.
- REQ-009: Port btn_pulse, output, N_BTN bits; one-cycle strobe per accepted press, plus auto-repeat strobes when that feature is compiled in.
- REQ-010: Port btn_release, output, N_BTN bits; one-cycle strobe per accepted release.

Function
- REQ-011: Each channel SHALL pass btn_raw[i] through a two-flop synchronizer; only the second flop's output (sync[i]) is used by downstream logic.
- REQ-012: Each channel SHALL have a debounce counter that increments on every cycle where sync[i] differs from btn_level[i], and clears on any cycle where they are equal.
- REQ-013: On the cycle the counter reaches DEBOUNCE_CYCLES, btn_level[i] SHALL toggle and the counter SHALL clear.
- REQ-014: If raw goes high before edge 1 and stays high, btn_level[i] SHALL rise after edge 2+DEBOUNCE_CYCLES; a release has the same latency.
- REQ-015: A raw disturbance lasting fewer than DEBOUNCE_CYCLES synchronized cycles SHALL change no output.
- REQ-016: btn_pulse[i] SHALL be high for exactly the one cycle in which btn_level[i] first reads 1.
- REQ-017: btn_release[i] SHALL be high for exactly the one cycle in which btn_level[i] first reads 0.
- REQ-018: Channels SHALL be fully independent; simultaneous presses produce pulses in the same cycle.
- REQ-019: Counters SHALL saturate and never wrap; counter widths are sized from the parameters.
- REQ-020: Setting DEBOUNCE_CYCLES=1 SHALL make btn_level follow sync with one cycle of delay.

Reset
- REQ-021: While reset is high at a clock edge, the synchronizers, btn_level, btn_pulse, btn_release, all counters and all repeat states SHALL clear to 0 / IDLE.
- REQ-022: A button held through reset SHALL be treated as a new press, with the full latency of REQ-014 measured from the first edge after reset deasserts.
- REQ-023: Reset asserted mid-debounce or mid-repeat SHALL abort that activity with no pulse emitted.

Configuration
- REQ-024: Macro BTN_AUTOREPEAT_EN, when defined, SHALL add a per-channel state machine with states IDLE, HELD_DELAY and HELD_REPEAT.
- REQ-025: Auto-repeat transitions SHALL be as follows:
  - IDLE to HELD_DELAY on the press pulse.
  - HELD_DELAY to HELD_REPEAT after REPEAT_DELAY cycles, emitting a btn_pulse.
  - In HELD_REPEAT, one btn_pulse every REPEAT_PERIOD cycles.
  - Any state to IDLE in the cycle btn_level falls; no repeat pulse may coincide with btn_release.
- REQ-026: When BTN_AUTOREPEAT_EN is undefined, no repeat logic SHALL exist, and btn_pulse fires only once per press.

Verification (bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
- REQ-027: Reset with btn_raw=0000 for 10 cycles -> all outputs stay 0000.
- REQ-028: btn_raw[1]=1 before edge 1, held -> btn_level[1] rises after edge 6; btn_pulse[1] is high only in the cycle after edge 6; other bits stay 0.
- REQ-029: btn_raw[2] high for 3 cycles, then 0 -> btn_level, btn_pulse and btn_release all stay 0.
- REQ-030: With BTN_AUTOREPEAT_EN, btn_raw[3] held -> pulses after edges 6, 16, 19 and 22; on release, btn_release[3] fires once 6 edges later and no further pulses occur. Without the macro, only the edge-6 pulse occurs.
- REQ-031: btn_raw[0] and btn_raw[3] rise together -> btn_pulse=1001 in a single cycle.
- REQ-032: Reset pulsed at edge 8 while btn_raw[1] is held -> outputs are 0 after edge 8; btn_pulse[1] recurs 6 edges after reset deasserts.
